// File: rtl/graycode_counter.sv
// Registered up/down Gray-code counter with sync clear/load and a terminal-count pulse.
// Optional macro GRAYCODE_CHECK_EN adds a sticky single-bit-step checker on gray_q.
module graycode_counter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned LOAD_IS_GRAY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [DATA_WIDTH-1:0] gray_q,
  output logic [DATA_WIDTH-1:0] bin_q,
  output logic                  tc,
  output logic                  gray_err
);

  localparam logic [DATA_WIDTH-1:0] RstBin  = DATA_WIDTH'(RESET_VALUE);
  localparam logic [DATA_WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);
  localparam logic [DATA_WIDTH-1:0] AllOnes = '1;
  localparam logic [DATA_WIDTH-1:0] AllZero = '0;

  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down recovers the binary value.
  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] bin_d;
  logic [DATA_WIDTH-1:0] gray_d;
  logic [DATA_WIDTH-1:0] load_bin;
  logic                  tc_d, tc_q;
  logic                  count_step;

  always_comb begin
    load_bin = (LOAD_IS_GRAY != 0) ? gray2bin(load_val) : load_val;
  end

  always_comb begin
    bin_d      = bin_q;
    tc_d       = 1'b0;
    count_step = 1'b0;
    if (clear) begin
      bin_d = RstBin;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      count_step = 1'b1;
      if (up) begin
        bin_d = bin_q + 1'b1;
        tc_d  = (bin_q == AllOnes);
      end else begin
        bin_d = bin_q - 1'b1;
        tc_d  = (bin_q == AllZero);
      end
    end
    // Gray copy is derived from the next binary value so both registers move together.
    gray_d = bin2gray(bin_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RstBin;
      gray_q <= RstGray;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign tc = tc_q;

`ifdef GRAYCODE_CHECK_EN
  logic [DATA_WIDTH-1:0] shadow_d, shadow_q;
  logic                  step_d, step_q;
  logic                  gray_err_d, gray_err_q;

  // step_q marks that the last edge was a count step, so gray_q vs shadow_q is a real step.
  always_comb begin
    shadow_d   = count_step ? gray_q : shadow_q;
    step_d     = count_step;
    gray_err_d = gray_err_q;
    if (clear) begin
      gray_err_d = 1'b0;
    end else if (step_q && ($countones(gray_q ^ shadow_q) != 1)) begin
      gray_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= RstGray;
      step_q     <= 1'b0;
      gray_err_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      step_q     <= step_d;
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err = gray_err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_graycode_counter.sv
// Directed bench for graycode_counter: three instances cover default, Gray-load and
// non-zero reset value configurations driven from shared stimulus.
module tb_graycode_counter;

  logic       clk = 1'b0;
  logic       rst, clear, load, en, up;
  logic [7:0] load_val;

  logic [7:0] a_gray, a_bin, g_gray, g_bin, r_gray, r_bin;
  logic       a_tc, a_err, g_tc, g_err, r_tc, r_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  graycode_counter #(.DATA_WIDTH(8), .RESET_VALUE(0), .LOAD_IS_GRAY(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .en(en), .up(up),
    .gray_q(a_gray), .bin_q(a_bin), .tc(a_tc), .gray_err(a_err)
  );

  graycode_counter #(.DATA_WIDTH(8), .RESET_VALUE(0), .LOAD_IS_GRAY(1)) dut_g (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .en(en), .up(up),
    .gray_q(g_gray), .bin_q(g_bin), .tc(g_tc), .gray_err(g_err)
  );

  graycode_counter #(.DATA_WIDTH(8), .RESET_VALUE(5), .LOAD_IS_GRAY(0)) dut_r (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .en(en), .up(up),
    .gray_q(r_gray), .bin_q(r_bin), .tc(r_tc), .gray_err(r_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] exp_b;
    logic [7:0] prev_g;

    rst = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 8'h00;
    #3;
    check("rst_a_bin", 32'(a_bin), 32'h00);
    check("rst_a_gray", 32'(a_gray), 32'h00);
    check("rst_a_tc", 32'(a_tc), 32'h0);
    check("rst_a_err", 32'(a_err), 32'h0);
    check("rst_r_bin", 32'(r_bin), 32'h05);
    check("rst_r_gray", 32'(r_gray), 32'h07);
    tick();
    rst = 1'b0;

    // Hold, then count down through the wrap.
    tick();
    check("hold_a_bin", 32'(a_bin), 32'h00);
    check("hold_a_tc", 32'(a_tc), 32'h0);
    en = 1'b1; up = 1'b0;
    tick();
    check("dn_wrap_bin", 32'(a_bin), 32'hFF);
    check("dn_wrap_gray", 32'(a_gray), 32'h80);
    check("dn_wrap_tc", 32'(a_tc), 32'h1);
    check("dn_r_bin", 32'(r_bin), 32'h04);
    check("dn_r_tc", 32'(r_tc), 32'h0);
    tick();
    check("dn2_bin", 32'(a_bin), 32'hFE);
    check("dn2_gray", 32'(a_gray), 32'h81);
    check("dn2_tc", 32'(a_tc), 32'h0);
    en = 1'b0;
    tick();
    check("hold2_bin", 32'(a_bin), 32'hFE);
    check("hold2_tc", 32'(a_tc), 32'h0);

    // Full up-count sweep with wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sweep_start", 32'(a_bin), 32'h00);
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      exp_b = 8'(k);
      check("sweep_bin", 32'(a_bin), 32'(exp_b));
      check("sweep_gray", 32'(a_gray), 32'(exp_b ^ (exp_b >> 1)));
      check("sweep_tc", 32'(a_tc), (k == 256) ? 32'h1 : 32'h0);
    end

    // Direction changes around zero.
    tick();
    check("dir_up_bin", 32'(a_bin), 32'h01);
    check("dir_up_gray", 32'(a_gray), 32'h01);
    up = 1'b0;
    tick();
    check("dir_dn_bin", 32'(a_bin), 32'h00);
    check("dir_dn_tc", 32'(a_tc), 32'h0);
    tick();
    check("dir_dn_wrap", 32'(a_bin), 32'hFF);
    check("dir_dn_wrap_tc", 32'(a_tc), 32'h1);
    up = 1'b1;
    tick();
    check("dir_up_wrap", 32'(a_bin), 32'h00);
    check("dir_up_wrap_tc", 32'(a_tc), 32'h1);
    en = 1'b0;

    // Loads: Gray-coded vs binary interpretation.
    load = 1'b1; load_val = 8'hC0;
    tick();
    check("gload_bin", 32'(g_bin), 32'h80);
    check("gload_gray", 32'(g_gray), 32'hC0);
    check("gload_tc", 32'(g_tc), 32'h0);
    check("bload_bin", 32'(a_bin), 32'hC0);
    check("bload_gray", 32'(a_gray), 32'hA0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("gload_step_bin", 32'(g_bin), 32'h81);
    check("gload_step_gray", 32'(g_gray), 32'hC1);
    check("bload_step_gray", 32'(a_gray), 32'hA1);
    en = 1'b0;
    load = 1'b1; load_val = 8'hFF;
    tick();
    check("load_ff_bin", 32'(a_bin), 32'hFF);
    check("load_ff_tc", 32'(a_tc), 32'h0);
    check("gload_ff_bin", 32'(g_bin), 32'hAA);
    load = 1'b0; en = 1'b1;
    tick();
    check("load_ff_wrap", 32'(a_bin), 32'h00);
    check("load_ff_wrap_tc", 32'(a_tc), 32'h1);
    check("gload_ff_step", 32'(g_bin), 32'hAB);
    check("gload_ff_gray", 32'(g_gray), 32'hFE);

    // Priority: clear > load > en.
    clear = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'h10;
    tick();
    check("clr_r_bin", 32'(r_bin), 32'h05);
    check("clr_r_gray", 32'(r_gray), 32'h07);
    check("clr_r_tc", 32'(r_tc), 32'h0);
    check("clr_a_bin", 32'(a_bin), 32'h00);
    clear = 1'b0;
    tick();
    check("ld_en_r_bin", 32'(r_bin), 32'h10);
    check("ld_en_r_gray", 32'(r_gray), 32'h18);
    check("ld_en_g_bin", 32'(g_bin), 32'h1F);
    check("ld_en_a_tc", 32'(a_tc), 32'h0);
    load = 1'b0; en = 1'b0;

    // Asynchronous reset mid-count.
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    repeat (8'h37) tick();
    check("pre_arst_bin", 32'(a_bin), 32'h37);
    check("pre_arst_gray", 32'(a_gray), 32'h2C);
    check("pre_arst_r_bin", 32'(r_bin), 32'h3C);
    #2 rst = 1'b1;
    #1;
    check("arst_a_bin", 32'(a_bin), 32'h00);
    check("arst_a_gray", 32'(a_gray), 32'h00);
    check("arst_r_bin", 32'(r_bin), 32'h05);
    check("arst_r_gray", 32'(r_gray), 32'h07);
    tick();
    check("arst_hold_bin", 32'(a_bin), 32'h00);
    rst = 1'b0;
    tick();
    check("resume_a_bin", 32'(a_bin), 32'h01);
    check("resume_a_gray", 32'(a_gray), 32'h01);
    check("resume_r_bin", 32'(r_bin), 32'h06);
    check("resume_r_gray", 32'(r_gray), 32'h05);
    en = 1'b0;
    check("err_idle", 32'(a_err), 32'h0);

`ifdef GRAYCODE_CHECK_EN
    for (int k = 0; k < 1000; k++) begin
      en = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      tick();
    end
    check("err_random", 32'(a_err), 32'h0);
    en = 1'b1; up = 1'b1;
    prev_g = a_gray;
    tick();
    force dut_a.gray_q = prev_g ^ 8'h03;
    en = 1'b0;
    tick();
    release dut_a.gray_q;
    check("err_set", 32'(a_err), 32'h1);
    tick();
    check("err_sticky", 32'(a_err), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("err_clear", 32'(a_err), 32'h0);
`else
    prev_g = a_gray;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("err_tied", 32'(a_err), 32'h0);
    check("step_gray_bits", 32'($countones(a_gray ^ prev_g)), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
